// File: rtl/tts_pkg.sv
// Shared definitions for the truth-table sequencer.
//   tts_state_e   : sequencer FSM states
//   N_IN_DEFAULT  : default number of network inputs (x1, x2)
//   NUM_VEC       : number of input combinations for the default input count
//   F1_TABLE      : truth table of F1(x1,x2) = x1 V x1*not(x2), which reduces to x1
//   num_vec()     : 2**n helper for sizing tables and counters
package tts_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tts_state_e;

  localparam int N_IN_DEFAULT = 2;
  localparam int NUM_VEC      = 2 ** N_IN_DEFAULT;

  // Bit i is F1 for input vector i, where vector bit 1 is x1.
  localparam logic [NUM_VEC-1:0] F1_TABLE = 4'b1100;

  function automatic int num_vec(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Settle interval timer.
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   clear : force the count back to zero (has priority over en)
//   en    : count one cycle of settling
//   tc    : high while enabled in the last settle cycle (count == SETTLE_CYCLES-1)
// SETTLE_CYCLES must be in 1..15.
module settle_timer
  import tts_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 4'd1;
    end
  end

  assign tc = en && (count == LAST);

endmodule

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: steps a gate network's inputs through every
// combination, waits a settle interval, samples the network output and
// compares it against the expected truth table.
//   clk              : system clock, rising edge
//   rst              : synchronous active-high reset
//   start            : pulse; begins a sweep from IDLE or DONE
//   abort            : pulse; returns to IDLE and clears results (beats start)
//   dut_out          : network output, already synchronous to clk
//   vec_out          : input vector to the network (MSB = x1)
//   busy             : high in SETTLE and SAMPLE
//   done             : high in DONE
//   pass             : high in DONE when no vector mismatched
//   err_count        : mismatching vectors in the last sweep
//   first_fail       : index of the first mismatching vector
//   first_fail_valid : first_fail holds a captured index
//   result_led       : copy of pass for the result LED
//   state_dbg        : current FSM state (tts_state_e encoding)
// Handshake: start and abort are single-cycle pulses sampled on the rising
// edge; there is no ready, a start outside IDLE/DONE is simply dropped.
module truth_table_sequencer
  import tts_pkg::*;
#(
  parameter int                    N_IN          = N_IN_DEFAULT,
  parameter int                    SETTLE_CYCLES = 2,
  parameter logic [2**N_IN-1:0]    EXPECTED      = F1_TABLE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            dut_out,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_valid,
  output logic            result_led,
  output logic [1:0]      state_dbg
);

  localparam int            NV       = num_vec(N_IN);
  localparam logic [N_IN:0] ERR_MAX  = (N_IN + 1)'(NV);
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  tts_state_e    state;
  logic          settle_done;
  logic          timer_clear;
  logic          timer_en;
  logic          mismatch;
  logic [N_IN:0] err_next;

  // Counter only runs in SETTLE and is held at zero everywhere else, so
  // every vector starts its settle interval from a clean count.
  assign timer_en    = (state == SETTLE);
  assign timer_clear = (state != SETTLE) || abort;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .en   (timer_en),
    .tc   (settle_done)
  );

  assign mismatch = (dut_out != EXPECTED[vec_out]);

  // Error count after this SAMPLE cycle; used so pass can be registered on
  // the same edge that enters DONE.
  always_comb begin
    err_next = err_count;
    if (mismatch && (err_count != ERR_MAX)) begin
      err_next = err_count + (N_IN + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state            <= IDLE;
      vec_out          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
      result_led       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= SETTLE;
            vec_out          <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
            result_led       <= 1'b0;
          end
        end
        SETTLE: begin
          if (settle_done) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          err_count <= err_next;
          if (mismatch && !first_fail_valid) begin
            first_fail       <= vec_out;
            first_fail_valid <= 1'b1;
          end
          if (vec_out == VEC_LAST) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            pass       <= (err_next == '0);
            result_led <= (err_next == '0);
          end else begin
            vec_out <= vec_out + N_IN'(1);
            state   <= SETTLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule
